int_sequencer: RTL and testbench

Interrupt entry sequencer for the five-stage pipeline. It captures an external interrupt edge, waits for a safe point, freezes fetch, and injects NOPs until in-flight instructions retire. It then pushes the 32-bit return PC and the flags to the stack through the memory stage port, reads the 32-bit handler vector from data memory, and redirects fetch. While it is active, it owns the PC/F-D enables and the memory-stage port; otherwise it is transparent.

---
 rtl/int_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_int_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: drains the pipeline, pushes the return PC and flags,
// fetches the handler vector and redirects fetch. Transparent while idle.
module int_sequencer #(
  parameter int             W        = 16,
  parameter int             DRAIN    = 3,
  parameter logic [W-1:0]   VEC_ADDR = W'(16'h0002)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq,
  input  logic             hold,
  input  logic             rti_done,
  input  logic [2*W-1:0]   pc_save,
  input  logic [2:0]       flags_in,
  input  logic [W-1:0]     sp,
  input  logic [W-1:0]     mem_rdata,
  output logic             pc_enb,
  output logic             f_d_enb,
  output logic             inject_nop,
  output logic             mem_own,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [W-1:0]     mem_addr,
  output logic [W-1:0]     mem_wdata,
  output logic             sp_dec,
  output logic             pc_load,
  output logic [2*W-1:0]   pc_load_val,
  output logic             int_ack,
  output logic             in_service
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_PUSH_H, S_PUSH_L, S_PUSH_F, S_RD_L, S_RD_H, S_JUMP
  } state_t;

  localparam int            CW          = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [CW-1:0] DRAIN_INIT  = CW'(DRAIN - 1);
  localparam logic [W-1:0]  VEC_HI_ADDR = VEC_ADDR + W'(1);

  state_t          state;
  logic            irq_q;
  logic            pending;
  logic [CW-1:0]   drain_cnt;
  logic [2*W-1:0]  ret_pc;
  logic [2:0]      sav_flags;
  logic [W-1:0]    vec_lo;
  logic [W-1:0]    vec_hi;
  logic            irq_rise;
  logic            entry_ok;

  assign irq_rise = irq & ~irq_q;
  assign entry_ok = (state == S_IDLE) & pending & ~hold & ~in_service;

  // A new edge always wins over the clear, so an edge coinciding with entry is kept for later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      irq_q      <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
      drain_cnt  <= '0;
      ret_pc     <= '0;
      sav_flags  <= '0;
      vec_lo     <= '0;
      vec_hi     <= '0;
    end else begin
      irq_q <= irq;
      if (irq_rise)
        pending <= 1'b1;
      else if (entry_ok)
        pending <= 1'b0;

      if (state == S_JUMP)
        in_service <= 1'b1;
      else if (rti_done)
        in_service <= 1'b0;

      case (state)
        S_IDLE: begin
          if (entry_ok) begin
            ret_pc    <= pc_save;
            sav_flags <= flags_in;
            drain_cnt <= DRAIN_INIT;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0)
            state <= S_PUSH_H;
          else
            drain_cnt <= drain_cnt - CW'(1);
        end
        S_PUSH_H: state <= S_PUSH_L;
        S_PUSH_L: state <= S_PUSH_F;
        S_PUSH_F: state <= S_RD_L;
        S_RD_L: begin
          vec_lo <= mem_rdata;
          state  <= S_RD_H;
        end
        S_RD_H: begin
          vec_hi <= mem_rdata;
          state  <= S_JUMP;
        end
        S_JUMP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode: the sp input already reflects earlier decrements, so each push uses it directly.
  always_comb begin
    pc_enb      = 1'b0;
    f_d_enb     = 1'b0;
    inject_nop  = 1'b0;
    mem_own     = 1'b0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sp_dec      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    int_ack     = 1'b0;
    case (state)
      S_IDLE: begin
        pc_enb  = 1'b1;
        f_d_enb = 1'b1;
      end
      S_DRAIN: inject_nop = 1'b1;
      S_PUSH_H: begin
        inject_nop = 1'b1;
        mem_own    = 1'b1;
        mem_wr     = 1'b1;
        sp_dec     = 1'b1;
        mem_addr   = sp;
        mem_wdata  = ret_pc[2*W-1:W];
      end
      S_PUSH_L: begin
        inject_nop = 1'b1;
        mem_own    = 1'b1;
        mem_wr     = 1'b1;
        sp_dec     = 1'b1;
        mem_addr   = sp;
        mem_wdata  = ret_pc[W-1:0];
      end
      S_PUSH_F: begin
        inject_nop = 1'b1;
        mem_own    = 1'b1;
        mem_wr     = 1'b1;
        sp_dec     = 1'b1;
        mem_addr   = sp;
        mem_wdata  = {{(W-3){1'b0}}, sav_flags};
      end
      S_RD_L: begin
        inject_nop = 1'b1;
        mem_own    = 1'b1;
        mem_rd     = 1'b1;
        mem_addr   = VEC_ADDR;
      end
      S_RD_H: begin
        inject_nop = 1'b1;
        mem_own    = 1'b1;
        mem_rd     = 1'b1;
        mem_addr   = VEC_HI_ADDR;
      end
      S_JUMP: begin
        pc_enb      = 1'b1;
        inject_nop  = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = {vec_hi, vec_lo};
        int_ack     = 1'b1;
      end
      default: begin
        pc_enb  = 1'b1;
        f_d_enb = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: table vectors, hand sequences (nesting, level irq,
// async reset mid-push) and random entries against a transaction-level model.
module tb_int_sequencer;
  localparam int           W        = 16;
  localparam int           DRAIN    = 3;
  localparam logic [W-1:0] VEC_ADDR = 16'h0002;

  logic          clk = 1'b0;
  logic          rst;
  logic          irq;
  logic          hold;
  logic          rti_done;
  logic [31:0]   pc_save;
  logic [2:0]    flags_in;
  logic [15:0]   sp;
  logic [15:0]   mem_rdata;
  logic          pc_enb, f_d_enb, inject_nop, mem_own, mem_wr, mem_rd;
  logic [15:0]   mem_addr, mem_wdata;
  logic          sp_dec, pc_load, int_ack, in_service;
  logic [31:0]   pc_load_val;

  logic [15:0]   sp_base = 16'h0800;
  logic [15:0]   vec_lo_v = 16'h0;
  logic [15:0]   vec_hi_v = 16'h0;
  logic [15:0]   dec_total = 16'h0;
  int            cyc = 0;
  int            ack_total = 0;
  int            ack_cyc = 0;
  logic [31:0]   ack_pcv = 32'h0;
  logic          ack_pcl = 1'b0;
  int            wr_count = 0;
  logic [31:0]   wr_log [0:1023];
  int            pce_low = 0;
  int            nop_cnt = 0;
  int            rd_cnt = 0;

  int            checks = 0;
  int            failures = 0;

  int            s_wr, s_ack, s_pce, s_nop, s_rd, start_cyc;
  logic [15:0]   s_dec;

  typedef struct {
    logic [15:0] sp;
    logic [31:0] pc;
    logic [2:0]  flags;
    logic [15:0] vlo;
    logic [15:0] vhi;
    int          hold_cycles;
    int          pulses;
    int          exp_lat;
    logic [15:0] exp_a0, exp_a1, exp_a2;
    logic [15:0] exp_hi, exp_lo, exp_fl;
    logic [31:0] exp_pcv;
  } vec_t;

  vec_t tbl [4];

  int_sequencer #(.W(W), .DRAIN(DRAIN), .VEC_ADDR(VEC_ADDR)) dut (
    .clk(clk), .rst(rst), .irq(irq), .hold(hold), .rti_done(rti_done),
    .pc_save(pc_save), .flags_in(flags_in), .sp(sp), .mem_rdata(mem_rdata),
    .pc_enb(pc_enb), .f_d_enb(f_d_enb), .inject_nop(inject_nop),
    .mem_own(mem_own), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_dec(sp_dec),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .int_ack(int_ack),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Environment: a stack pointer that follows sp_dec, and a data memory holding the vector.
  assign sp = sp_base - dec_total;
  assign mem_rdata = (mem_addr == VEC_ADDR) ? vec_lo_v :
                     (mem_addr == VEC_ADDR + 16'd1) ? vec_hi_v : 16'hDEAD;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sp_dec) dec_total <= dec_total + 16'd1;
  end

  // Transaction monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (int_ack) begin
      ack_total <= ack_total + 1;
      ack_cyc   <= cyc;
      ack_pcv   <= pc_load_val;
      ack_pcl   <= pc_load;
    end
    if (mem_wr && wr_count < 1024) begin
      wr_log[wr_count] <= {mem_addr, mem_wdata};
      wr_count         <= wr_count + 1;
    end
    if (!pc_enb)    pce_low <= pce_low + 1;
    if (inject_nop) nop_cnt <= nop_cnt + 1;
    if (mem_rd)     rd_cnt  <= rd_cnt + 1;
  end

  // Reference model: what one interrupt entry must produce, from the entry rules alone.
  function automatic vec_t model(input logic [15:0] sp_v, input logic [31:0] pc_v,
                                 input logic [2:0] fl, input logic [15:0] vlo,
                                 input logic [15:0] vhi, input int h, input int p);
    vec_t e;
    e.sp = sp_v; e.pc = pc_v; e.flags = fl; e.vlo = vlo; e.vhi = vhi;
    e.hold_cycles = h; e.pulses = p;
    e.exp_lat = ((h > 1) ? h : 1) + DRAIN + 6;
    e.exp_a0 = sp_v;
    e.exp_a1 = sp_v - 16'd1;
    e.exp_a2 = sp_v - 16'd2;
    e.exp_hi = pc_v[31:16];
    e.exp_lo = pc_v[15:0];
    e.exp_fl = {13'b0, fl};
    e.exp_pcv = {vhi, vlo};
    return e;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    s_wr = wr_count; s_ack = ack_total; s_pce = pce_low;
    s_nop = nop_cnt; s_rd = rd_cnt; s_dec = dec_total; start_cyc = cyc;
  endtask

  task automatic apply_stimulus(input vec_t e);
    pc_save  = e.pc;
    flags_in = e.flags;
    vec_lo_v = e.vlo;
    vec_hi_v = e.vhi;
    sp_base  = e.sp + dec_total;
  endtask

  // Drives hold/irq per edge after the trigger, waits for the acknowledge, then checks the transaction.
  task automatic await_entry(input vec_t e, input string tag);
    bit got = 0;
    int lat;
    for (int j = 0; j < 80 && !got; j++) begin
      step();
      rti_done = 1'b0;
      if (ack_total != s_ack) got = 1;
      irq  = (j + 1 <= 2 * e.pulses) ? ((j + 1) % 2 == 0) : 1'b1;
      hold = (j + 1 < e.hold_cycles);
    end
    check_output({tag, " ack seen"}, 64'(got), 64'd1);
    lat = ack_cyc - start_cyc;
    step();
    step();
    check_output({tag, " latency"}, 64'(lat), 64'(e.exp_lat));
    check_output({tag, " ack count"}, 64'(ack_total - s_ack), 64'd1);
    check_output({tag, " pc_load with ack"}, 64'(ack_pcl), 64'd1);
    check_output({tag, " pc_load_val"}, 64'(ack_pcv), 64'(e.exp_pcv));
    check_output({tag, " write count"}, 64'(wr_count - s_wr), 64'd3);
    check_output({tag, " push hi"}, 64'(wr_log[s_wr]), 64'({e.exp_a0, e.exp_hi}));
    check_output({tag, " push lo"}, 64'(wr_log[s_wr + 1]), 64'({e.exp_a1, e.exp_lo}));
    check_output({tag, " push flags"}, 64'(wr_log[s_wr + 2]), 64'({e.exp_a2, e.exp_fl}));
    check_output({tag, " sp decrements"}, 64'(16'(dec_total - s_dec)), 64'd3);
    check_output({tag, " frozen cycles"}, 64'(pce_low - s_pce), 64'(DRAIN + 5));
    check_output({tag, " nop cycles"}, 64'(nop_cnt - s_nop), 64'(DRAIN + 6));
    check_output({tag, " read cycles"}, 64'(rd_cnt - s_rd), 64'd2);
    check_output({tag, " in_service"}, 64'(in_service), 64'd1);
  endtask

  task automatic run_entry(input vec_t e, input string tag);
    step();
    irq  = 1'b0;
    hold = 1'b0;
    apply_stimulus(e);
    step();
    snap();
    irq  = 1'b1;
    hold = (e.hold_cycles > 0);
    await_entry(e, tag);
  endtask

  task automatic end_service(input string tag);
    step();
    rti_done = 1'b1;
    step();
    rti_done = 1'b0;
    check_output({tag, " service ended"}, 64'(in_service), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t nv, rv, re;
    rst = 1'b0; irq = 1'b0; hold = 1'b0; rti_done = 1'b0;
    pc_save = 32'h0; flags_in = 3'b0;
    #2;
    check_output("reset strobes",
                 64'({pc_enb, f_d_enb, inject_nop, mem_own, mem_wr, mem_rd, sp_dec, pc_load, int_ack, in_service}),
                 64'b11_0000_0000);
    check_output("reset buses", {mem_addr, mem_wdata, pc_load_val}, 64'h0);
    repeat (3) step();
    rst = 1'b1;
    step();

    tbl[0] = '{16'h07FF, 32'h0000_0120, 3'b101, 16'h0300, 16'h0000, 0, 0, 10,
               16'h07FF, 16'h07FE, 16'h07FD, 16'h0000, 16'h0120, 16'h0005, 32'h0000_0300};
    tbl[1] = '{16'h1000, 32'hABCD_1234, 3'b010, 16'h5678, 16'h0001, 5, 0, 14,
               16'h1000, 16'h0FFF, 16'h0FFE, 16'hABCD, 16'h1234, 16'h0002, 32'h0001_5678};
    tbl[2] = '{16'h0002, 32'h0000_FFFF, 3'b111, 16'h0000, 16'hFFFF, 5, 2, 14,
               16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0007, 32'hFFFF_0000};
    tbl[3] = '{16'h0000, 32'h8000_0001, 3'b000, 16'h0001, 16'h8000, 1, 0, 10,
               16'h0000, 16'hFFFF, 16'hFFFE, 16'h8000, 16'h0001, 16'h0000, 32'h8000_0001};

    for (int i = 0; i < 4; i++) begin
      run_entry(tbl[i], $sformatf("vec%0d", i));
      end_service($sformatf("vec%0d", i));
    end

    // irq is still high from the last entry: a held level must not re-enter.
    snap();
    repeat (20) step();
    check_output("level no reentry ack", 64'(ack_total - s_ack), 64'd0);
    check_output("level no reentry freeze", 64'(pce_low - s_pce), 64'd0);

    // Nesting: an edge while in service waits for RTI, then enters with the new pc_save.
    run_entry(tbl[0], "nest first");
    step(); irq = 1'b0;
    step(); irq = 1'b1;
    snap();
    repeat (15) step();
    check_output("nest deferred ack", 64'(ack_total - s_ack), 64'd0);
    check_output("nest deferred pc_enb", 64'(pc_enb), 64'd1);
    nv = model(16'h0400, 32'h1234_5678, 3'b011, 16'h4444, 16'h0002, 0, 0);
    apply_stimulus(nv);
    snap();
    rti_done = 1'b1;
    await_entry(nv, "nest second");
    end_service("nest second");

    // Asynchronous reset while PUSH_L is on the bus.
    rv = model(16'h0900, 32'hCAFE_BEEF, 3'b110, 16'h0123, 16'h0004, 0, 0);
    step();
    irq = 1'b0;
    apply_stimulus(rv);
    step();
    irq = 1'b1;
    repeat (6) step();
    check_output("pre-reset push lo", 64'({mem_wr, mem_wdata}), 64'({1'b1, 16'hBEEF}));
    #1 rst = 1'b0;
    #1;
    check_output("async reset strobes",
                 64'({pc_enb, f_d_enb, inject_nop, mem_own, mem_wr, mem_rd, sp_dec, pc_load, int_ack, in_service}),
                 64'b11_0000_0000);
    check_output("async reset buses", {mem_addr, mem_wdata, pc_load_val}, 64'h0);
    irq = 1'b0;
    step();
    rst = 1'b1;
    step();
    run_entry(rv, "after reset");
    end_service("after reset");

    for (int k = 0; k < 10; k++) begin
      int h, p;
      p = $urandom_range(0, 2);
      h = $urandom_range(0, 6);
      if (p > 0 && h < 2 * p + 1) h = 2 * p + 1;
      re = model(16'($urandom), $urandom, 3'($urandom), 16'($urandom), 16'($urandom), h, p);
      run_entry(re, $sformatf("rand%0d", k));
      end_service($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
